// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-counter FSM state encodings, the sequential
// fetch increment and the default reset PC.
// No ports (package only).
package cpu_pkg;

    // 2-bit encodings are fixed so other blocks can decode the state bits directly.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2
    } pc_state_e;

    localparam int unsigned INSTR_BYTES_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

endpackage

// File: rtl/pc_target_adder.sv
// Branch/jump target adder: PC+4 plus a word-aligned byte offset.
// Ports:
//   pc_plus4_i - address of the instruction after the current one
//   offset_i   - sign-extended byte offset; bits [1:0] are ignored
//   target_o   - 32-bit modulo sum (carry out discarded)
module pc_target_adder (
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] offset_i,
    output logic [31:0] target_o
);

    // Masking keeps the target word aligned even if the offset is not.
    assign target_o = pc_plus4_i + (offset_i & 32'hFFFF_FFFC);

endmodule

// File: rtl/pc_update_unit.sv
// Program counter owner. Picks the next fetch address (sequential, jump or taken
// beq), holds on cache BUSYWAIT and remembers the first taken target seen
// during a stall so it is applied when the stall ends.
// Ports:
//   CLK, RESET            - clock, synchronous active-high reset
//   BUSYWAIT              - cache stall; PC holds while high
//   JUMP, BRANCH, ZERO    - control of the current instruction
//   EXTENDED_VAL          - sign-extended byte offset
//   PC, PC_PLUS4          - current fetch address and its successor
//   REDIRECT              - pulses when PC loads a taken target
//   FETCH_VALID           - PC may be used by the pipeline
module pc_update_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic        JUMP,
    input  logic        BRANCH,
    input  logic        ZERO,
    input  logic [31:0] EXTENDED_VAL,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        REDIRECT,
    output logic        FETCH_VALID
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        redirect_q, redirect_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        taken;
    logic [31:0] target;

    // JUMP and a taken beq produce the same target, so no priority is needed.
    assign taken = JUMP | (BRANCH & ZERO);

    pc_target_adder u_target_adder (
        .pc_plus4_i (pc_plus4_q),
        .offset_i   (EXTENDED_VAL),
        .target_o   (target)
    );

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + 32'(INSTR_BYTES);
            redirect_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            redirect_q    <= redirect_d;
            fetch_valid_q <= fetch_valid_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   if (BUSYWAIT) state_d = StStall;
            StStall: if (!BUSYWAIT) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values.
    always_comb begin
        pc_d          = pc_q;
        redirect_d    = 1'b0;
        fetch_valid_d = 1'b1;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        unique case (state_q)
            StIdle: begin
                // Control is ignored; PC stays at the reset address for one cycle.
            end
            StRun: begin
                if (BUSYWAIT) begin
                    if (taken) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = target;
                    end
                end else begin
                    pc_d       = taken ? target : pc_plus4_q;
                    redirect_d = taken;
                end
            end
            StStall: begin
                if (BUSYWAIT) begin
                    // First capture wins; later control changes are ignored.
                    if (!pend_valid_q && taken) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = target;
                    end
                end else begin
                    if (pend_valid_q) begin
                        pc_d = pend_target_q;
                    end else begin
                        pc_d = taken ? target : pc_plus4_q;
                    end
                    redirect_d   = pend_valid_q | taken;
                    pend_valid_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
        pc_plus4_d = pc_d + 32'(INSTR_BYTES);
    end

    assign PC          = pc_q;
    assign PC_PLUS4    = pc_plus4_q;
    assign REDIRECT    = redirect_q;
    assign FETCH_VALID = fetch_valid_q;

endmodule

// File: tb/tb_pc_update_unit.sv
module tb_pc_update_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        BUSYWAIT = 1'b0;
    logic        JUMP = 1'b0;
    logic        BRANCH = 1'b0;
    logic        ZERO = 1'b0;
    logic [31:0] EXTENDED_VAL = 32'h0;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        REDIRECT;
    logic        FETCH_VALID;

    pc_update_unit dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUSYWAIT     (BUSYWAIT),
        .JUMP         (JUMP),
        .BRANCH       (BRANCH),
        .ZERO         (ZERO),
        .EXTENDED_VAL (EXTENDED_VAL),
        .PC           (PC),
        .PC_PLUS4     (PC_PLUS4),
        .REDIRECT     (REDIRECT),
        .FETCH_VALID  (FETCH_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        redirect;
        logic        fetch_valid;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: architectural view of the fetch unit.
    logic [31:0] m_pc = 32'h0;
    logic        m_fv = 1'b0;
    logic        m_red = 1'b0;
    bit          m_first = 1'b1;   // first cycle after reset release
    logic [31:0] m_pend[$];        // at most one remembered target

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected result.
    task automatic step(input bit rst, input bit bw, input bit j, input bit b, input bit z,
                        input logic [31:0] ev);
        bit          tk;
        logic [31:0] tgt;
        exp_t        e;
        RESET = rst; BUSYWAIT = bw; JUMP = j; BRANCH = b; ZERO = z; EXTENDED_VAL = ev;
        tk  = j || (b && z);
        tgt = m_pc + 32'd4 + (ev & ~32'd3);
        if (rst) begin
            m_pc = 32'h0; m_fv = 1'b0; m_red = 1'b0; m_first = 1'b1;
            m_pend.delete();
        end else if (m_first) begin
            m_first = 1'b0; m_fv = 1'b1; m_red = 1'b0;
        end else if (bw) begin
            m_red = 1'b0;
            if (tk && m_pend.size() == 0) m_pend.push_back(tgt);
        end else if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front(); m_red = 1'b1;
        end else if (tk) begin
            m_pc = tgt; m_red = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4; m_red = 1'b0;
        end
        e.pc = m_pc; e.pc_plus4 = m_pc + 32'd4; e.redirect = m_red; e.fetch_valid = m_fv;
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 32'h0);
    endtask

    // Jump to an absolute address using the model's current PC.
    task automatic goto(input logic [31:0] addr);
        step(0, 0, 1, 0, 0, addr - (m_pc + 32'd4));
    endtask

    // Monitor: DUT updates every edge; compare just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", PC, e.pc);
                chk("pc_plus4", PC_PLUS4, e.pc_plus4);
                chk("redirect", {31'h0, REDIRECT}, {31'h0, e.redirect});
                chk("fetch_valid", {31'h0, FETCH_VALID}, {31'h0, e.fetch_valid});
            end
        end
    end

    initial begin
        // 1. Reset, idle cycle, sequential fetch.
        step(1, 0, 0, 0, 0, 32'h0);
        step(1, 1, 1, 1, 1, 32'h40);
        idle_step();
        repeat (4) idle_step();
        // 2. Backward jump from 0x10.
        goto(32'h10);
        step(0, 0, 1, 0, 0, 32'hFFFF_FFF8);
        idle_step();
        // 3. Branch not taken, then taken.
        goto(32'h08);
        step(0, 0, 0, 1, 0, 32'h20);
        goto(32'h08);
        step(0, 0, 0, 1, 1, 32'h20);
        idle_step();
        // 4. Taken branch under a 3-cycle stall, control dropped after cycle 1.
        goto(32'h20);
        step(0, 1, 0, 1, 1, 32'h40);
        step(0, 1, 0, 0, 0, 32'h0);
        step(0, 1, 1, 0, 0, 32'h80);   // ignored: first capture wins
        idle_step();
        idle_step();
        // 5. Wrap-around.
        goto(32'hFFFF_FFFC);
        idle_step();
        goto(32'hFFFF_FFF8);
        step(0, 0, 1, 0, 0, 32'h8);
        idle_step();
        // Misaligned offset bits are ignored.
        step(0, 0, 1, 0, 0, 32'h13);
        // 6. Reset mid-stall discards the pending target.
        goto(32'h40);
        step(0, 1, 1, 0, 0, 32'h100 - 32'h44);
        step(1, 1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 32'h0);
        idle_step();
        idle_step();
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 1) == 1), $urandom());
        end
        repeat (3) idle_step();
        @(posedge CLK);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
